// File: rtl/add_pkg.sv
// Shared constants for the sequential byte-slice add/subtract unit.
package add_pkg;

    localparam int unsigned SLICE = 8;

    typedef logic [1:0] state_t;
    localparam state_t IDLE = 2'd0;
    localparam state_t ADD  = 2'd1;
    localparam state_t DONE = 2'd2;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

endpackage

// File: rtl/add16_seq_fadd8.sv
// 8-bit ripple adder slice shared across all byte positions.
module fadd8 (
    output logic [7:0] s,
    output logic       cout,
    input  logic [7:0] x,
    input  logic [7:0] y,
    input  logic       cin
);

    logic [8:0] carry_c;

    // Bitwise ripple chain
    always_comb begin
        carry_c    = '0;
        s          = '0;
        carry_c[0] = cin;
        for (int i = 0; i < 8; i++) begin
            s[i]           = x[i] ^ y[i] ^ carry_c[i];
            carry_c[i + 1] = (x[i] & y[i]) | (carry_c[i] & (x[i] ^ y[i]));
        end
        cout = carry_c[8];
    end

endmodule

// File: rtl/add16_seq.sv
// Multi-cycle add/subtract: one byte slice per cycle through a single fadd8,
// operands in and result plus {N,Z,C,V} out over valid/ready.
module add16_seq
    import add_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic [3:0]       flags
);

    localparam int unsigned N     = WIDTH / SLICE;
    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned MSB   = WIDTH - 1;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_r_q, a_r_d;
    logic [WIDTH-1:0]   b_eff_q, b_eff_d;
    logic               carry_q, carry_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic [3:0]         flags_q, flags_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;

    logic [SLICE-1:0]   fa_x_c, fa_y_c, fa_s_c;
    logic               fa_cout_c;
    logic               last_c;

    assign last_c = (idx_q == IDX_W'(N - 1));

    // Select the active byte slice of each operand
    always_comb begin
        fa_x_c = a_r_q[32'(idx_q) * SLICE +: SLICE];
        fa_y_c = b_eff_q[32'(idx_q) * SLICE +: SLICE];
    end

    fadd8 u_fadd8 (
        .s    (fa_s_c),
        .cout (fa_cout_c),
        .x    (fa_x_c),
        .y    (fa_y_c),
        .cin  (carry_q)
    );

    // State register and all datapath/output flops
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_r_q       <= '0;
            b_eff_q     <= '0;
            carry_q     <= 1'b0;
            idx_q       <= '0;
            sum_q       <= '0;
            flags_q     <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_r_q       <= a_r_d;
            b_eff_q     <= b_eff_d;
            carry_q     <= carry_d;
            idx_q       <= idx_d;
            sum_q       <= sum_d;
            flags_q     <= flags_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid && in_ready_q) state_d = ADD;
            ADD:     if (last_c) state_d = DONE;
            DONE:    if (out_valid_q && out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operand capture, slice write-back, flags and handshake outputs
    always_comb begin
        a_r_d       = a_r_q;
        b_eff_d     = b_eff_q;
        carry_d     = carry_q;
        idx_d       = idx_q;
        sum_d       = sum_q;
        flags_d     = flags_q;
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    a_r_d   = a;
                    b_eff_d = sub ? ~b : b;
                    carry_d = sub ? 1'b1 : cin;
                    idx_d   = '0;
                end
            end
            ADD: begin
                sum_d[32'(idx_q) * SLICE +: SLICE] = fa_s_c;
                carry_d = fa_cout_c;
                idx_d   = idx_q + IDX_W'(1);
                if (last_c) begin
                    // Z looks at the sum including the slice written this cycle
                    flags_d[FLAG_N] = fa_s_c[SLICE-1];
                    flags_d[FLAG_Z] = (sum_d == '0);
                    flags_d[FLAG_C] = fa_cout_c;
                    flags_d[FLAG_V] = (a_r_q[MSB] == b_eff_q[MSB]) &&
                                      (fa_s_c[SLICE-1] != a_r_q[MSB]);
                end
            end
            default: ;
        endcase
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign flags     = flags_q;

endmodule
